// File: rtl/ising_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// ising_ctrl_pkg
// Shared definitions for the Ising annealing sequencer: wrapper register
// address map, the phase register stride, the FSM state encodings of the
// sequencer and of the phase reader, and a saturating 32-bit add.
// No ports (package).
// ---------------------------------------------------------------------------
package ising_ctrl_pkg;

   localparam logic [31:0] ADDR_START      = 32'h0000_0500;
   localparam logic [31:0] ADDR_CTR_CUTOFF = 32'h0000_0600;
   localparam logic [31:0] ADDR_CTR_MAX    = 32'h0000_0700;
   localparam logic [31:0] ADDR_PHASE_BASE = 32'h0000_0800;
   localparam logic [31:0] PHASE_STRIDE    = 32'd4;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_WR_MAX,
      ST_WR_HOLD,
      ST_WR_CUT,
      ST_WR_GO,
      ST_DWELL,
      ST_READ,     // phase reader owns the bus (RD_REQ / RD_WAIT loop)
      ST_STEP,
      ST_WR_STOP,
      ST_DONE
   } state_e;

   typedef enum logic [1:0] {
      RS_IDLE,
      RS_REQ,
      RS_WAIT
   } rd_state_e;

   // Cutoff ramp must never wrap: clamp at all-ones.
   function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] b);
      logic [32:0] s;
      s = {1'b0, a} + {1'b0, b};
      return s[32] ? 32'hFFFF_FFFF : s[31:0];
   endfunction

endpackage

// File: rtl/ising_phase_reader.sv
// ---------------------------------------------------------------------------
// ising_phase_reader
// Reads the N phase registers of the wrapper one bit at a time
// (RD_REQ: one-cycle arvalid pulse, RD_WAIT: rready until rvalid) and
// collects them in a shadow register.
// Optional feature macro: READ_TIMEOUT_EN -- bounds each RD_WAIT to TIMEOUT
// cycles and reports err_o instead of waiting forever.
// Ports:
//   clk, axi_rstn        clock, async active-low reset
//   start_i              begin a read sweep at bit 0
//   rvalid_i, rdata0_i   read response valid, phase bit (rdata[0])
//   arvalid_o, araddr_o  read request pulse and address
//   rready_o             read-response accept
//   done_o               last bit accepted this cycle (phase_o is complete)
//   err_o                read timeout this cycle (READ_TIMEOUT_EN only)
//   phase_o              shadow including the bit being accepted this cycle
// ---------------------------------------------------------------------------
module ising_phase_reader
   import ising_ctrl_pkg::*;
#(
   parameter int unsigned N       = 3,
   parameter int unsigned TIMEOUT = 16
)(
   input  logic          clk,
   input  logic          axi_rstn,
   input  logic          start_i,
   input  logic          rvalid_i,
   input  logic          rdata0_i,
   output logic          arvalid_o,
   output logic [31:0]   araddr_o,
   output logic          rready_o,
   output logic          done_o,
   output logic          err_o,
   output logic [N-1:0]  phase_o
);

   localparam int unsigned   BW       = (N > 1) ? $clog2(N) : 1;
   localparam logic [BW-1:0] LAST_BIT = BW'(N - 1);

   rd_state_e       st_q, st_d;
   logic [BW-1:0]   bit_q, bit_d;
   logic [N-1:0]    shadow_q, shadow_d;

`ifdef READ_TIMEOUT_EN
   localparam int unsigned   TW       = $clog2(TIMEOUT + 1);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
   logic [TW-1:0]   tmo_q, tmo_d;
`endif

   always_ff @(posedge clk or negedge axi_rstn) begin
      if (!axi_rstn) begin
         st_q     <= RS_IDLE;
         bit_q    <= '0;
         shadow_q <= '0;
`ifdef READ_TIMEOUT_EN
         tmo_q    <= '0;
`endif
      end else begin
         st_q     <= st_d;
         bit_q    <= bit_d;
         shadow_q <= shadow_d;
`ifdef READ_TIMEOUT_EN
         tmo_q    <= tmo_d;
`endif
      end
   end

   always_comb begin
      st_d     = st_q;
      bit_d    = bit_q;
      shadow_d = shadow_q;
`ifdef READ_TIMEOUT_EN
      tmo_d    = tmo_q;
`endif
      case (st_q)
         RS_IDLE: begin
            if (start_i) begin
               st_d  = RS_REQ;
               bit_d = '0;
            end
         end
         RS_REQ: begin
            st_d = RS_WAIT;
`ifdef READ_TIMEOUT_EN
            tmo_d = '0;
`endif
         end
         RS_WAIT: begin
            if (rvalid_i) begin
               shadow_d[bit_q] = rdata0_i;
               if (bit_q == LAST_BIT) begin
                  st_d = RS_IDLE;
               end else begin
                  bit_d = bit_q + BW'(1);
                  st_d  = RS_REQ;
               end
            end else begin
`ifdef READ_TIMEOUT_EN
               if (err_o) st_d = RS_IDLE;
               else       tmo_d = tmo_q + TW'(1);
`endif
            end
         end
         default: st_d = RS_IDLE;
      endcase
   end

   always_comb begin
      arvalid_o = (st_q == RS_REQ);
      araddr_o  = arvalid_o ? (ADDR_PHASE_BASE + PHASE_STRIDE * 32'(bit_q)) : '0;
      rready_o  = (st_q == RS_WAIT);
      done_o    = rready_o && rvalid_i && (bit_q == LAST_BIT);
`ifdef READ_TIMEOUT_EN
      err_o     = rready_o && !rvalid_i && (tmo_q == TMO_LAST);
`else
      err_o     = 1'b0;
`endif
   end

   // The sequencer latches this on done_o, so the result only ever moves
   // by a whole step's worth of bits.
   assign phase_o = shadow_d;

endmodule

// File: rtl/ising_anneal_ctrl.sv
// ---------------------------------------------------------------------------
// ising_anneal_ctrl
// Bus-master sequencer that walks the Ising machine wrapper through a
// multi-step annealing schedule: CTR_MAX once, then per step hold START=0,
// program a ramped CTR_CUTOFF, START=1, dwell, read back all N phases.
// Finishes with START=0.
// Optional feature macro: READ_TIMEOUT_EN (read-response timeout -> rd_err).
// Ports:
//   clk, axi_rstn                 clock, async active-low reset
//   go                            start request (IDLE only)
//   cfg_*                         schedule configuration, latched on go
//   busy, done, rd_err            status (done is a level until next go)
//   step_idx, phase_result        current step, phases of last full step
//   wready, wr_addr, wdata        one-cycle write strobe to the wrapper
//   arvalid_q, araddr_q, rready   read request / accept
//   rvalid, rdata                 read response (rdata[0] = phase)
// ---------------------------------------------------------------------------
module ising_anneal_ctrl
   import ising_ctrl_pkg::*;
#(
   parameter int unsigned N       = 3,
   parameter int unsigned DWELL_W = 32,
   parameter int unsigned STEP_W  = 16,
   parameter int unsigned TIMEOUT = 16
)(
   input  logic                clk,
   input  logic                axi_rstn,
   input  logic                go,
   input  logic [31:0]         cfg_counter_max,
   input  logic [31:0]         cfg_cutoff_start,
   input  logic [31:0]         cfg_cutoff_step,
   input  logic [STEP_W-1:0]   cfg_num_steps,
   input  logic [DWELL_W-1:0]  cfg_dwell,
   output logic                busy,
   output logic                done,
   output logic                rd_err,
   output logic [STEP_W-1:0]   step_idx,
   output logic [N-1:0]        phase_result,
   output logic                wready,
   output logic [31:0]         wr_addr,
   output logic [31:0]         wdata,
   output logic                arvalid_q,
   output logic [31:0]         araddr_q,
   output logic                rready,
   input  logic                rvalid,
   input  logic [31:0]         rdata
);

   state_e               state_q, state_d;
   logic [31:0]          ctr_max_q, ctr_max_d;
   logic [31:0]          cut_step_q, cut_step_d;
   logic [31:0]          cutoff_q, cutoff_d;
   logic [STEP_W-1:0]    num_steps_q, num_steps_d;
   logic [STEP_W-1:0]    step_q, step_d;
   logic [DWELL_W-1:0]   dwell_q, dwell_d;
   logic [DWELL_W-1:0]   dwell_cnt_q, dwell_cnt_d;
   logic                 done_q, done_d;
   logic                 rd_err_q, rd_err_d;
   logic [N-1:0]         phase_q, phase_d;

   logic                 rd_start, rd_done, rd_fail;
   logic [N-1:0]         rd_phase;
   logic                 unused_rdata;

   // Only the phase bit of a read response is meaningful.
   assign unused_rdata = ^rdata[31:1];

   ising_phase_reader #(
      .N       (N),
      .TIMEOUT (TIMEOUT)
   ) u_reader (
      .clk       (clk),
      .axi_rstn  (axi_rstn),
      .start_i   (rd_start),
      .rvalid_i  (rvalid),
      .rdata0_i  (rdata[0]),
      .arvalid_o (arvalid_q),
      .araddr_o  (araddr_q),
      .rready_o  (rready),
      .done_o    (rd_done),
      .err_o     (rd_fail),
      .phase_o   (rd_phase)
   );

   always_ff @(posedge clk or negedge axi_rstn) begin
      if (!axi_rstn) begin
         state_q     <= ST_IDLE;
         ctr_max_q   <= '0;
         cut_step_q  <= '0;
         cutoff_q    <= '0;
         num_steps_q <= '0;
         step_q      <= '0;
         dwell_q     <= '0;
         dwell_cnt_q <= '0;
         done_q      <= 1'b0;
         rd_err_q    <= 1'b0;
         phase_q     <= '0;
      end else begin
         state_q     <= state_d;
         ctr_max_q   <= ctr_max_d;
         cut_step_q  <= cut_step_d;
         cutoff_q    <= cutoff_d;
         num_steps_q <= num_steps_d;
         step_q      <= step_d;
         dwell_q     <= dwell_d;
         dwell_cnt_q <= dwell_cnt_d;
         done_q      <= done_d;
         rd_err_q    <= rd_err_d;
         phase_q     <= phase_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      ctr_max_d   = ctr_max_q;
      cut_step_d  = cut_step_q;
      cutoff_d    = cutoff_q;
      num_steps_d = num_steps_q;
      step_d      = step_q;
      dwell_d     = dwell_q;
      dwell_cnt_d = dwell_cnt_q;
      done_d      = done_q;
      rd_err_d    = rd_err_q;
      phase_d     = phase_q;
      case (state_q)
         ST_IDLE: begin
            if (go) begin
               ctr_max_d   = cfg_counter_max;
               cut_step_d  = cfg_cutoff_step;
               cutoff_d    = cfg_cutoff_start;
               num_steps_d = cfg_num_steps;
               dwell_d     = cfg_dwell;
               step_d      = '0;
               rd_err_d    = 1'b0;
               // An empty schedule completes immediately with no bus traffic.
               if (cfg_num_steps == '0) begin
                  done_d  = 1'b1;
                  state_d = ST_DONE;
               end else begin
                  done_d  = 1'b0;
                  state_d = ST_WR_MAX;
               end
            end
         end
         ST_WR_MAX:  state_d = ST_WR_HOLD;
         ST_WR_HOLD: state_d = ST_WR_CUT;
         ST_WR_CUT:  state_d = ST_WR_GO;
         ST_WR_GO: begin
            // Counts down to zero inclusive, so load D-1; dwell 0 acts as 1.
            dwell_cnt_d = (dwell_q == '0) ? '0 : dwell_q - DWELL_W'(1);
            state_d     = ST_DWELL;
         end
         ST_DWELL: begin
            if (dwell_cnt_q == '0) state_d = ST_READ;
            else                   dwell_cnt_d = dwell_cnt_q - DWELL_W'(1);
         end
         ST_READ: begin
            if (rd_done) begin
               phase_d = rd_phase;
               state_d = ST_STEP;
            end else if (rd_fail) begin
               rd_err_d = 1'b1;
               state_d  = ST_WR_STOP;
            end
         end
         ST_STEP: begin
            // Widened compare so num_steps at full scale still terminates.
            if (({1'b0, step_q} + (STEP_W+1)'(1)) == {1'b0, num_steps_q}) begin
               state_d = ST_WR_STOP;
            end else begin
               step_d   = step_q + STEP_W'(1);
               cutoff_d = sat_add32(cutoff_q, cut_step_q);
               state_d  = ST_WR_HOLD;
            end
         end
         ST_WR_STOP: begin
            done_d  = 1'b1;
            state_d = ST_DONE;
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      wready  = 1'b0;
      wr_addr = '0;
      wdata   = '0;
      case (state_q)
         ST_WR_MAX: begin
            wready  = 1'b1;
            wr_addr = ADDR_CTR_MAX;
            wdata   = ctr_max_q;
         end
         ST_WR_HOLD, ST_WR_STOP: begin
            wready  = 1'b1;
            wr_addr = ADDR_START;
            wdata   = 32'd0;
         end
         ST_WR_CUT: begin
            wready  = 1'b1;
            wr_addr = ADDR_CTR_CUTOFF;
            wdata   = cutoff_q;
         end
         ST_WR_GO: begin
            wready  = 1'b1;
            wr_addr = ADDR_START;
            wdata   = 32'd1;
         end
         default: ;
      endcase
      // Reader starts on the last dwell cycle so RD_REQ follows DWELL directly.
      rd_start = (state_q == ST_DWELL) && (dwell_cnt_q == '0);
      busy     = (state_q != ST_IDLE) && (state_q != ST_DONE);
   end

   assign done         = done_q;
   assign rd_err       = rd_err_q;
   assign step_idx     = step_q;
   assign phase_result = phase_q;

endmodule

// File: tb/tb_ising_anneal_ctrl.sv
module tb_ising_anneal_ctrl;
   localparam int N       = 3;
   localparam int STEP_W  = 16;
   localparam int DWELL_W = 32;
   localparam int TIMEOUT = 16;

   logic                clk;
   logic                axi_rstn;
   logic                go;
   logic [31:0]         cfg_counter_max, cfg_cutoff_start, cfg_cutoff_step;
   logic [STEP_W-1:0]   cfg_num_steps;
   logic [DWELL_W-1:0]  cfg_dwell;
   logic                busy, done, rd_err;
   logic [STEP_W-1:0]   step_idx;
   logic [N-1:0]        phase_result;
   logic                wready;
   logic [31:0]         wr_addr, wdata;
   logic                arvalid_q;
   logic [31:0]         araddr_q;
   logic                rready;
   logic                rvalid;
   logic [31:0]         rdata;

   ising_anneal_ctrl #(.N(N), .DWELL_W(DWELL_W), .STEP_W(STEP_W), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .axi_rstn(axi_rstn), .go(go),
      .cfg_counter_max(cfg_counter_max), .cfg_cutoff_start(cfg_cutoff_start),
      .cfg_cutoff_step(cfg_cutoff_step), .cfg_num_steps(cfg_num_steps), .cfg_dwell(cfg_dwell),
      .busy(busy), .done(done), .rd_err(rd_err), .step_idx(step_idx), .phase_result(phase_result),
      .wready(wready), .wr_addr(wr_addr), .wdata(wdata),
      .arvalid_q(arvalid_q), .araddr_q(araddr_q), .rready(rready),
      .rvalid(rvalid), .rdata(rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      bit          is_rd;
      logic [31:0] addr;
      logic [31:0] data;
   } ev_t;

   ev_t          exp_q[$];
   logic [31:0]  cut_obs[$];
   logic [N-1:0] phases_tab [0:15];
   logic [N-1:0] model_phase;
   int           errors = 0;
   int           checks = 0;
   int           go_writes = 0;
   int           n_pulses = 0;
   int           n_max_wr = 0;
   bit           rsp_en = 1'b1;
   bit           prev_ar = 1'b0;

   task automatic chk(input string nm, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Wrapper model: answers one cycle after each read request with the
   // phase of the current step for the addressed spin; upper bits are noise.
   function automatic bit phase_bit(input logic [31:0] a);
      int unsigned idx;
      int g;
      idx = (a - 32'h800) >> 2;
      g   = go_writes - 1;
      if (g < 0 || idx >= N) return 1'b0;
      return phases_tab[g % 16][idx];
   endfunction

   always @(posedge clk or negedge axi_rstn) begin
      if (!axi_rstn) begin
         rvalid <= 1'b0;
         rdata  <= '0;
      end else begin
         rvalid <= arvalid_q && rsp_en;
         rdata  <= {31'($urandom), phase_bit(araddr_q)};
      end
   end

   // Compare process: every bus event against the expected event list.
   always @(negedge clk) begin
      ev_t e;
      if (axi_rstn) begin
         if (wready) begin
            n_pulses++;
            chk("wr_expected", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
               e = exp_q.pop_front();
               chk("wr_kind", e.is_rd, 0);
               chk("wr_addr", wr_addr, e.addr);
               chk("wdata", wdata, e.data);
            end
            if (wr_addr == 32'h700) n_max_wr++;
            if (wr_addr == 32'h600) cut_obs.push_back(wdata);
            if (wr_addr == 32'h500 && wdata == 32'd1) go_writes++;
         end else begin
            chk("wr_addr_idle", wr_addr, 0);
            chk("wdata_idle", wdata, 0);
         end
         if (arvalid_q) begin
            n_pulses++;
            chk("rd_expected", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
               e = exp_q.pop_front();
               chk("rd_kind", e.is_rd, 1);
               chk("araddr", araddr_q, e.addr);
            end
         end else begin
            chk("araddr_idle", araddr_q, 0);
         end
         if (rsp_en) chk("rready", rready, prev_ar);
         prev_ar = arvalid_q;
      end else begin
         prev_ar = 1'b0;
      end
   end

   // Builds the expected bus sequence straight from the schedule rules.
   task automatic build_exp(input logic [31:0] mx, input logic [31:0] cs, input logic [31:0] st,
                            input int S, input bit tmo);
      longint cut;
      exp_q.delete();
      cut_obs.delete();
      n_max_wr  = 0;
      n_pulses  = 0;
      go_writes = 0;
      if (S == 0) return;
      exp_q.push_back('{0, 32'h700, mx});
      cut = cs;
      for (int s = 0; s < S; s++) begin
         exp_q.push_back('{0, 32'h500, 32'd0});
         exp_q.push_back('{0, 32'h600, 32'(cut)});
         exp_q.push_back('{0, 32'h500, 32'd1});
         if (tmo) begin
            exp_q.push_back('{1, 32'h800, 32'd0});
            break;
         end
         for (int b = 0; b < N; b++) exp_q.push_back('{1, 32'h800 + 32'(4 * b), 32'd0});
         cut = cut + st;
         if (cut > 64'hFFFF_FFFF) cut = 64'hFFFF_FFFF;
      end
      exp_q.push_back('{0, 32'h500, 32'd0});
   endtask

   task automatic rand_phases();
      for (int i = 0; i < 16; i++) phases_tab[i] = N'($urandom);
   endtask

   task automatic scramble_cfg();
      cfg_counter_max  = $urandom;
      cfg_cutoff_start = $urandom;
      cfg_cutoff_step  = $urandom;
      cfg_num_steps    = STEP_W'($urandom_range(1, 9));
      cfg_dwell        = $urandom_range(0, 9);
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_rd_err"}, rd_err, 0);
      chk({tag, "_step_idx"}, step_idx, 0);
      chk({tag, "_phase"}, phase_result, 0);
      chk({tag, "_wready"}, wready, 0);
      chk({tag, "_wr_addr"}, wr_addr, 0);
      chk({tag, "_wdata"}, wdata, 0);
      chk({tag, "_arvalid"}, arvalid_q, 0);
      chk({tag, "_araddr"}, araddr_q, 0);
      chk({tag, "_rready"}, rready, 0);
   endtask

   task automatic run(input logic [31:0] mx, input logic [31:0] cs, input logic [31:0] st,
                      input int S, input int D, input bit mid_go, input bit tmo, output int lat);
      int           deff;
      int           exp_lat;
      logic [N-1:0] exp_ph;
      deff = (D == 0) ? 1 : D;
      build_exp(mx, cs, st, S, tmo);
      if (S == 0)   exp_lat = 0;
      else if (tmo) exp_lat = 4 + deff + 1 + TIMEOUT + 1;
      else          exp_lat = S * (4 + deff + 2 * N) + 2;
      exp_ph = (S == 0 || tmo) ? model_phase : phases_tab[S - 1];
      rsp_en = !tmo;
      @(negedge clk);
      cfg_counter_max  = mx;
      cfg_cutoff_start = cs;
      cfg_cutoff_step  = st;
      cfg_num_steps    = STEP_W'(S);
      cfg_dwell        = DWELL_W'(D);
      go               = 1'b1;
      @(posedge clk);
      #1;
      go = 1'b0;
      scramble_cfg();
      chk("busy_after_go", busy, (S > 0) ? 1 : 0);
      lat = 0;
      while (!done && lat < 3000) begin
         go = (mid_go && lat == 5);
         @(posedge clk);
         #1;
         lat++;
      end
      go = 1'b0;
      chk("done_latency", lat, exp_lat);
      chk("step_idx", step_idx, (S == 0 || tmo) ? 0 : S - 1);
      chk("phase_result", phase_result, exp_ph);
      chk("rd_err", rd_err, tmo ? 1 : 0);
      chk("busy_at_done", busy, 0);
      chk("events_left", exp_q.size(), 0);
      model_phase = exp_ph;
      repeat (2) @(posedge clk);
      #1;
      chk("done_level", done, 1);
      rsp_en = 1'b1;
   endtask

   initial begin
      int lat;
      logic [31:0] cs;
      axi_rstn = 1'b0;
      go       = 1'b0;
      cfg_counter_max  = '0;
      cfg_cutoff_start = '0;
      cfg_cutoff_step  = '0;
      cfg_num_steps    = '0;
      cfg_dwell        = '0;
      model_phase      = '0;
      rand_phases();
      #12;
      check_all_zero("reset");
      @(negedge clk);
      axi_rstn = 1'b1;

      // Reference case: N=3, S=1, D=4, phases 101 -> done at cycle 16.
      rand_phases();
      phases_tab[0] = 3'b101;
      run(32'h1234, 32'h40, 32'd3, 1, 4, 1'b0, 1'b0, lat);
      chk("pin_latency16", lat, 16);
      chk("pin_phase101", phase_result, 3'b101);
      chk("pin_cut0", (cut_obs.size() > 0) ? cut_obs[0] : 32'hDEAD, 32'h40);

      // Three-step ramp, with a go pulse mid-run that must be ignored.
      rand_phases();
      run(32'h99, 32'd10, 32'd5, 3, 2, 1'b1, 1'b0, lat);
      chk("ramp_ncut", cut_obs.size(), 3);
      if (cut_obs.size() == 3) begin
         chk("ramp_cut0", cut_obs[0], 10);
         chk("ramp_cut1", cut_obs[1], 15);
         chk("ramp_cut2", cut_obs[2], 20);
      end
      chk("ramp_max_once", n_max_wr, 1);
      chk("ramp_step_idx2", step_idx, 2);

      // Cutoff saturation.
      rand_phases();
      run(32'h7, 32'hFFFF_FFF0, 32'h20, 2, 1, 1'b0, 1'b0, lat);
      chk("sat_ncut", cut_obs.size(), 2);
      if (cut_obs.size() == 2) chk("sat_cut1", cut_obs[1], 32'hFFFF_FFFF);

      // Empty schedule.
      run(32'h5, 32'h6, 32'h7, 0, 3, 1'b0, 1'b0, lat);
      chk("zero_latency", lat, 0);
      chk("zero_no_pulses", n_pulses, 0);

      // Asynchronous reset during DWELL, then a fresh run.
      rand_phases();
      build_exp(32'h11, 32'h22, 32'h33, 2, 1'b0);
      @(negedge clk);
      cfg_counter_max = 32'h11; cfg_cutoff_start = 32'h22; cfg_cutoff_step = 32'h33;
      cfg_num_steps   = 16'd2;  cfg_dwell = 32'd30;
      go = 1'b1;
      @(posedge clk);
      #1;
      go = 1'b0;
      repeat (6) @(posedge clk);
      #2;
      chk("pre_reset_busy", busy, 1);
      axi_rstn = 1'b0;
      #1;
      check_all_zero("midreset");
      exp_q.delete();
      model_phase = '0;
      @(negedge clk);
      axi_rstn = 1'b1;
      rand_phases();
      run(32'hABCD, 32'h100, 32'h10, 2, 3, 1'b0, 1'b0, lat);

      // Randomized schedules.
      for (int r = 0; r < 8; r++) begin
         rand_phases();
         cs = $urandom_range(0, 1) ? (32'hFFFF_FF00 | 32'($urandom_range(0, 255))) : $urandom;
         run($urandom, cs, $urandom_range(0, 1) ? 32'($urandom_range(0, 300)) : $urandom,
             $urandom_range(1, 4), $urandom_range(0, 6), r[0], 1'b0, lat);
      end

`ifdef READ_TIMEOUT_EN
      // No read response ever: timeout, START=0, done, phases untouched.
      rand_phases();
      run(32'h55, 32'h66, 32'h77, 2, 2, 1'b0, 1'b1, lat);
      chk("tmo_latency", lat, 4 + 2 + 1 + TIMEOUT + 1);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
